// File: rtl/e203_subsys_rstgen_req.sv
// Reset-request generator: merges sw/wdg/dbg requests into a stretched, ack-confirmed active-low reset.
// Optional sticky cause register enabled by defining E203_RSTGEN_CAUSE_EN.
`timescale 1ns/1ps
module e203_subsys_rstgen_req #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned ACK_SYNC_LEVELS = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst_n_a,
    input  logic       test_mode,
    input  logic       sw_rst_req,
    input  logic       wdg_rst_req,
    input  logic       dbg_rst_req,
    input  logic       rst_ack_n,
    output logic       rst_n_out,
    output logic       busy,
    output logic       ack_timeout,
    output logic [3:0] cause,
    input  logic       cause_clr
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  rst_n_q, rst_n_d;
    logic                  busy_q, busy_d;
    logic                  ack_timeout_q;
    logic                  tmo_fire;
    logic                  req_any;
    logic                  ack_s;
    logic [ACK_SYNC_LEVELS-1:0] ack_sync_q;

    assign req_any = sw_rst_req | wdg_rst_req | dbg_rst_req;

    // Acknowledge synchronizer; resets to "destination in reset".
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[ACK_SYNC_LEVELS-2:0], rst_ack_n};
        end
    end

    assign ack_s = ack_sync_q[ACK_SYNC_LEVELS-1];

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d  = state_q;
        hold_d   = HOLD_MAX;
        tmo_d    = '0;
        tmo_fire = 1'b0;
        rst_n_d  = (state_q != ST_ASSERT);
        case (state_q)
            ST_ASSERT: begin
                if (req_any) begin
                    hold_d = HOLD_MAX;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d = '0;
                end
                if ((hold_q == '0) && ack_s && (tmo_q != TMO_LAST)) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end else begin
                    tmo_d = tmo_q;
                end
                if ((hold_q == '0) && !req_any) begin
                    if (!ack_s) begin
                        state_d = ST_RELEASE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d  = ST_RELEASE;
                        tmo_fire = 1'b1;
                    end
                end
                // RELEASE starts its own wait from zero.
                if (state_d != ST_ASSERT) begin
                    tmo_d = '0;
                end
            end
            ST_RELEASE: begin
                if (req_any) begin
                    state_d = ST_ASSERT;
                end else if (ack_s) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_IDLE;
                    tmo_fire = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                if (req_any) begin
                    state_d = ST_ASSERT;
                end
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state_q       <= ST_ASSERT;
            hold_q        <= HOLD_MAX;
            tmo_q         <= '0;
            rst_n_q       <= 1'b0;
            busy_q        <= 1'b1;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            tmo_q         <= tmo_d;
            rst_n_q       <= rst_n_d;
            busy_q        <= busy_d;
            ack_timeout_q <= tmo_fire;
        end
    end

`ifdef E203_RSTGEN_CAUSE_EN
    logic [3:0] cause_q;
    logic [3:0] cause_set;

    assign cause_set = {tmo_fire, dbg_rst_req, wdg_rst_req, sw_rst_req};

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            cause_q <= 4'b0000;
        end else begin
            cause_q <= (cause_clr ? 4'b0000 : cause_q) | cause_set;
        end
    end

    assign cause = cause_q;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = cause_clr;
    assign cause            = 4'b0000;
`endif

    // DFT bypass hands scan control of downstream resets to the pin.
    assign rst_n_out   = test_mode ? rst_n_a : rst_n_q;
    assign busy        = busy_q;
    assign ack_timeout = ack_timeout_q;

endmodule

// File: tb/tb_e203_subsys_rstgen_req.sv
// Directed bench for e203_subsys_rstgen_req: low-pulse lengths scored through a queue,
// plus cause, busy, ack_timeout and test_mode checks.
`timescale 1ns/1ps
module tb_e203_subsys_rstgen_req;

    localparam int unsigned HOLD = 16;
    localparam int unsigned TMO  = 64;

    logic       clk = 1'b0;
    logic       rst_n_a;
    logic       test_mode;
    logic       sw_rst_req;
    logic       wdg_rst_req;
    logic       dbg_rst_req;
    logic       rst_ack_n;
    logic       rst_n_out;
    logic       busy;
    logic       ack_timeout;
    logic [3:0] cause;
    logic       cause_clr;

    logic [1:0] ack_m;
    logic       stuck;

    int n_chk  = 0;
    int n_pass = 0;
    int low_run = 0;
    int tmo_pulses = 0;
    int meas_q[$];
    int exp_q[$];
    int t0;

    always #5 clk = ~clk;

    e203_subsys_rstgen_req #(
        .HOLD_CYCLES    (HOLD),
        .ACK_SYNC_LEVELS(2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n_a    (rst_n_a),
        .test_mode  (test_mode),
        .sw_rst_req (sw_rst_req),
        .wdg_rst_req(wdg_rst_req),
        .dbg_rst_req(dbg_rst_req),
        .rst_ack_n  (rst_ack_n),
        .rst_n_out  (rst_n_out),
        .busy       (busy),
        .ack_timeout(ack_timeout),
        .cause      (cause),
        .cause_clr  (cause_clr)
    );

    // Destination domain: two-flop synchronizer of rst_n_out, optionally stuck out of reset.
    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) ack_m <= 2'b00;
        else          ack_m <= {ack_m[0], rst_n_out};
    end
    assign rst_ack_n = stuck ? 1'b1 : ack_m[1];

    // Measures every completed low pulse of rst_n_out and counts ack_timeout cycles.
    always @(negedge clk) begin
        if (ack_timeout === 1'b1) tmo_pulses++;
        if (rst_n_a !== 1'b1) begin
            low_run = 0;
        end else if (rst_n_out === 1'b0) begin
            low_run++;
        end else if (low_run != 0) begin
            meas_q.push_back(low_run);
            low_run = 0;
        end
    end

    function automatic logic [3:0] exp_cause(input logic [3:0] v);
`ifdef E203_RSTGEN_CAUSE_EN
        return v;
`else
        return 4'b0000 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req(input logic s, input logic w, input logic d);
        sw_rst_req  = s;
        wdg_rst_req = w;
        dbg_rst_req = d;
        step(1);
        sw_rst_req  = 1'b0;
        wdg_rst_req = 1'b0;
        dbg_rst_req = 1'b0;
    endtask

    task automatic wait_pulse(input string tag);
        int k = 0;
        while (meas_q.size() == 0 && k < 400) begin
            step(1);
            k++;
        end
        chk({tag, "_seen"}, 32'(meas_q.size() > 0), 32'd1);
        if (meas_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_len"}, meas_q.pop_front(), exp_q.pop_front());
        else if (exp_q.size() > 0)
            void'(exp_q.pop_front());
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (busy !== 1'b0 && k < lim) begin
            step(1);
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_cause();
        cause_clr = 1'b1;
        step(1);
        cause_clr = 1'b0;
        chk("cause_cleared", 32'(cause), 32'd0);
    endtask

    initial begin
        rst_n_a     = 1'b0;
        test_mode   = 1'b0;
        sw_rst_req  = 1'b0;
        wdg_rst_req = 1'b0;
        dbg_rst_req = 1'b0;
        cause_clr   = 1'b0;
        stuck       = 1'b0;
        step(3);

        chk("rst_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ack_timeout", 32'(ack_timeout), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);

        // Power-on: full hold pulse after rst_n_a deasserts.
        exp_q.push_back(HOLD);
        @(negedge clk);
        #1 rst_n_a = 1'b1;
        wait_pulse("por");
        chk("por_busy_after_rise", 32'(busy), 32'd1);
        wait_idle("por", 10);
        chk("por_cause", 32'(cause), 32'd0);

        // Single-cycle software request.
        exp_q.push_back(HOLD);
        pulse_req(1'b1, 1'b0, 1'b0);
        wait_pulse("sw");
        wait_idle("sw", 20);
        chk("sw_cause", 32'(cause), 32'(exp_cause(4'b0001)));
        clear_cause();

        // Watchdog level held 40 cycles: low until HOLD cycles past the last request cycle.
        exp_q.push_back(40 + HOLD - 1);
        wdg_rst_req = 1'b1;
        step(40);
        chk("wdg_held_low", 32'(rst_n_out), 32'd0);
        wdg_rst_req = 1'b0;
        wait_pulse("wdg");
        wait_idle("wdg", 20);
        chk("wdg_cause", 32'(cause), 32'(exp_cause(4'b0010)));
        clear_cause();

        // Acknowledge never arrives: hold, then a full timeout wait.
        stuck = 1'b1;
        t0 = tmo_pulses;
        exp_q.push_back(HOLD + TMO - 1);
        pulse_req(1'b1, 1'b0, 1'b0);
        wait_pulse("tmo");
        wait_idle("tmo", 20);
        stuck = 1'b0;
        chk("tmo_pulse_count", 32'(tmo_pulses - t0), 32'd1);
        chk("tmo_cause", 32'(cause), 32'(exp_cause(4'b1001)));
        clear_cause();

        // Debug request while waiting for the ack in RELEASE restarts a full hold.
        exp_q.push_back(HOLD);
        pulse_req(1'b1, 1'b0, 1'b0);
        wait_pulse("rel_first");
        chk("rel_out_high", 32'(rst_n_out), 32'd1);
        chk("rel_busy", 32'(busy), 32'd1);
        exp_q.push_back(HOLD);
        pulse_req(1'b0, 1'b0, 1'b1);
        chk("rel_busy_kept", 32'(busy), 32'd1);
        wait_pulse("rel_dbg");
        wait_idle("rel", 20);
        chk("rel_cause", 32'(cause), 32'(exp_cause(4'b0101)));

        // Clear coinciding with a software request: the new sw bit survives.
        cause_clr  = 1'b1;
        exp_q.push_back(HOLD);
        pulse_req(1'b1, 1'b0, 1'b0);
        cause_clr  = 1'b0;
        chk("clr_sw_cause", 32'(cause), 32'(exp_cause(4'b0001)));
        wait_pulse("clr_sw");
        wait_idle("clr_sw", 20);
        clear_cause();

        // Simultaneous requests: one pulse, all causes recorded.
        exp_q.push_back(HOLD);
        pulse_req(1'b1, 1'b1, 1'b1);
        wait_pulse("all");
        wait_idle("all", 20);
        chk("all_cause", 32'(cause), 32'(exp_cause(4'b0111)));
        chk("all_single_pulse", 32'(meas_q.size()), 32'd0);

        // Asynchronous reset from IDLE takes effect without a clock.
        rst_n_a = 1'b0;
        #1;
        chk("mid_rst_out", 32'(rst_n_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_cause", 32'(cause), 32'd0);
        exp_q.push_back(HOLD);
        @(negedge clk);
        #1 rst_n_a = 1'b1;
        wait_pulse("mid_rst");
        wait_idle("mid_rst", 20);

        // DFT bypass: rst_n_out is the reset pin while the FSM runs on its own.
        t0 = tmo_pulses;
        test_mode = 1'b1;
        #1 chk("tm_idle_out", 32'(rst_n_out), 32'd1);
        rst_n_a = 1'b0;
        #1 chk("tm_low_out", 32'(rst_n_out), 32'd0);
        #3 rst_n_a = 1'b1;
        #1 chk("tm_high_out", 32'(rst_n_out), 32'd1);
        chk("tm_fsm_busy", 32'(busy), 32'd1);
        wait_idle("tm", 200);
        chk("tm_tmo_pulse", 32'(tmo_pulses - t0), 32'd1);
        test_mode = 1'b0;
        #1 chk("tm_exit_out", 32'(rst_n_out), 32'd1);
        step(2);

        chk("queues_empty", 32'(meas_q.size() + exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
